// File: rtl/port_bus_master.sv
// Port-bus master: queues write/read/commit commands in a small FIFO and
// replays them onto a strobed port bus, capturing read data into a response.
module port_bus_master #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [7:0] rsp_addr,
  output logic [7:0] port_id,
  output logic [7:0] out_port,
  output logic       write_strobe,
  output logic       read_strobe,
  input  logic [7:0] in_port,
  output logic       upd_sysregs,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_COMMIT
  } state_e;

  state_e state_q, state_d;

  logic [17:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [7:0] port_id_q, port_id_d;
  logic [7:0] out_port_q, out_port_d;
  logic       cur_rd_q, cur_rd_d;

  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic [7:0] rsp_addr_q, rsp_addr_d;

  logic        full, empty, push, pop, cap;
  logic [17:0] head;
  logic [1:0]  hd_op;
  logic [7:0]  hd_addr, hd_wdata;
  logic        hd_wr, hd_rd, hd_cm;

  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign empty     = (cnt_q == '0);
  assign cmd_ready = !full && !reset;
  assign push      = cmd_valid && cmd_ready;

  assign head     = mem_q[rd_ptr_q];
  assign hd_op    = head[17:16];
  assign hd_addr  = head[15:8];
  assign hd_wdata = head[7:0];
  assign hd_wr    = (hd_op == 2'b00);
  assign hd_rd    = (hd_op == 2'b01);
  assign hd_cm    = (hd_op == 2'b10);

  // Storage needs no reset: the count alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_op, cmd_addr, cmd_wdata};
    end
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    port_id_d  = port_id_q;
    out_port_d = out_port_q;
    cur_rd_d   = cur_rd_q;
    unique case (state_q)
      S_SETUP: begin
        if (!(cur_rd_q && rsp_valid_q && !rsp_ready)) begin
          state_d = S_STROBE;
        end
      end
      default: begin
        // IDLE, STROBE and COMMIT all end here, so each may issue the next.
        state_d = S_IDLE;
        if (!empty) begin
          pop = 1'b1;
          unique case (1'b1)
            hd_wr: begin
              state_d    = S_SETUP;
              port_id_d  = hd_addr;
              out_port_d = hd_wdata;
              cur_rd_d   = 1'b0;
            end
            hd_rd: begin
              state_d   = S_SETUP;
              port_id_d = hd_addr;
              cur_rd_d  = 1'b1;
            end
            hd_cm: begin
              state_d = S_COMMIT;
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  assign cap = (state_q == S_STROBE) && cur_rd_q;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    if (cap) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = in_port;
      rsp_addr_d  = port_id_q;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      port_id_q   <= '0;
      out_port_q  <= '0;
      cur_rd_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      port_id_q   <= port_id_d;
      out_port_q  <= out_port_d;
      cur_rd_q    <= cur_rd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
    end
  end

  assign port_id      = port_id_q;
  assign out_port     = out_port_q;
  assign write_strobe = (state_q == S_STROBE) && !cur_rd_q;
  assign read_strobe  = (state_q == S_STROBE) && cur_rd_q;
  assign upd_sysregs  = (state_q == S_COMMIT);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_addr     = rsp_addr_q;
  assign busy         = (state_q != S_IDLE) || !empty;

endmodule
